// File: rtl/debounce_bank.sv
// Multi-channel button conditioner: 2-flop synchroniser, shared sample tick,
// consecutive-sample stability filter, edge pulses and per-channel auto-repeat.
module debounce_bank #(
    parameter int N_CH         = 9,
    parameter int TICK_DIV     = 3000000,
    parameter int STABLE_N     = 4,
    parameter int REPEAT_DELAY = 15,
    parameter int REPEAT_RATE  = 5
) (
    input  logic            clk,
    input  logic            btn_reset,
    input  logic [N_CH-1:0] raw_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] press_pulse,
    output logic            tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;
    localparam int RW = $clog2(REPEAT_DELAY + 1);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_N - 1);
    localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);

    logic [N_CH-1:0] sync1_q, sync1_d;
    logic [N_CH-1:0] sync2_q, sync2_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick_q, tick_d;

    always_comb begin
        sync1_d    = raw_in;
        sync2_d    = sync1_q;
        tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
        // tick_q is high exactly while the counter sits at its last value
        tick_d     = (tick_cnt_d == TICK_LAST);
    end

    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [SW-1:0] stab_cnt_q, stab_cnt_d;
        logic [RW-1:0] rep_cnt_q, rep_cnt_d;
        logic          level_q, level_d;
        logic          rise_q, rise_d;
        logic          fall_q, fall_d;
        logic          press_q, press_d;
        logic          flip;
        logic          rep_evt;

        always_comb begin
            stab_cnt_d = stab_cnt_q;
            level_d    = level_q;
            flip       = 1'b0;
            if (tick_q) begin
                if (sync2_q[gi] == level_q) begin
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    flip       = 1'b1;
                    level_d    = sync2_q[gi];
                    stab_cnt_d = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + SW'(1);
                end
            end

            rep_cnt_d = rep_cnt_q;
            rep_evt   = 1'b0;
            if (!level_q || !repeat_en[gi]) begin
                rep_cnt_d = '0;
            end else if (tick_q) begin
                // A release tick must not also fire a repeat
                if (flip) begin
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == REP_LAST) begin
                    rep_evt   = 1'b1;
                    rep_cnt_d = REP_RELOAD;
                end else begin
                    rep_cnt_d = rep_cnt_q + RW'(1);
                end
            end

            rise_d  = flip & ~level_q;
            fall_d  = flip & level_q;
            press_d = rise_d | rep_evt;
        end

        always_ff @(posedge clk or posedge btn_reset) begin
            if (btn_reset) begin
                stab_cnt_q <= '0;
                rep_cnt_q  <= '0;
                level_q    <= 1'b0;
                rise_q     <= 1'b0;
                fall_q     <= 1'b0;
                press_q    <= 1'b0;
            end else begin
                stab_cnt_q <= stab_cnt_d;
                rep_cnt_q  <= rep_cnt_d;
                level_q    <= level_d;
                rise_q     <= rise_d;
                fall_q     <= fall_d;
                press_q    <= press_d;
            end
        end

        assign level_out[gi]   = level_q;
        assign rise_pulse[gi]  = rise_q;
        assign fall_pulse[gi]  = fall_q;
        assign press_pulse[gi] = press_q;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with a small tick divider so latencies and
// repeat spacing are short enough to check cycle by cycle.
module tb_debounce_bank;

    localparam int N_CH         = 9;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_N     = 3;
    localparam int REPEAT_DELAY = 5;
    localparam int REPEAT_RATE  = 2;

    logic            clk = 1'b0;
    logic            btn_reset = 1'b1;
    logic [N_CH-1:0] raw_in = '0;
    logic [N_CH-1:0] repeat_en = '0;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
    logic [N_CH-1:0] press_pulse;
    logic            tick;

    int              n_assert = 0;
    int              n_fail = 0;
    logic            mon_en = 1'b0;
    logic [N_CH-1:0] prev_level = '0;

    debounce_bank #(
        .N_CH        (N_CH),
        .TICK_DIV    (TICK_DIV),
        .STABLE_N    (STABLE_N),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk        (clk),
        .btn_reset  (btn_reset),
        .raw_in     (raw_in),
        .repeat_en  (repeat_en),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .press_pulse(press_pulse),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_lvl(input int ch, input logic val, input int max_cyc, output int lat);
        lat = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (level_out[ch] == val) begin
                lat = k;
                break;
            end
        end
    endtask

    // Edge pulses must track level changes exactly; press must cover every rise
    always @(negedge clk) begin
        if (mon_en && !btn_reset) begin
            check_val("rise_mon", 32'(rise_pulse), 32'(level_out & ~prev_level));
            check_val("fall_mon", 32'(fall_pulse), 32'(~level_out & prev_level));
            check_val("press_has_rise", 32'(rise_pulse & ~press_pulse), 32'd0);
        end
        prev_level <= level_out;
    end

    initial begin
        int              lat;
        int              np;
        int              pt[4];
        logic [11:0]     tpat;
        logic            acc;

        repeat (5) @(negedge clk);
        check_val("rst_level", 32'(level_out), 32'd0);
        check_val("rst_rise", 32'(rise_pulse), 32'd0);
        check_val("rst_fall", 32'(fall_pulse), 32'd0);
        check_val("rst_press", 32'(press_pulse), 32'd0);
        check_val("rst_tick", 32'(tick), 32'd0);
        $display("reset: outputs level=%0h press=%0h tick=%0b", level_out, press_pulse, tick);

        btn_reset = 1'b0;
        mon_en    = 1'b1;
        tpat      = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            tpat[k] = tick;
        end
        check_val("tick_pattern", 32'(tpat), 32'h444);
        $display("tick: pattern over 12 cycles = %03h", tpat);

        // Channel 0 clean press
        raw_in[0] = 1'b1;
        wait_lvl(0, 1'b1, 20, lat);
        check_val("ch0_lat_ok", 32'(lat >= 11 && lat <= 14), 32'd1);
        check_val("ch0_level", 32'(level_out), 32'h001);
        check_val("ch0_rise", 32'(rise_pulse), 32'h001);
        check_val("ch0_press", 32'(press_pulse), 32'h001);
        @(negedge clk);
        check_val("ch0_rise_1cyc", 32'(rise_pulse), 32'd0);
        check_val("ch0_press_1cyc", 32'(press_pulse), 32'd0);
        check_val("ch0_level_hold", 32'(level_out), 32'h001);
        $display("ch0 rise: latency %0d cycles", lat);

        // Channel 1 glitch of 8 cycles must be rejected
        acc = 1'b0;
        raw_in[1] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            acc |= level_out[1] | rise_pulse[1] | fall_pulse[1] | press_pulse[1];
        end
        raw_in[1] = 1'b0;
        repeat (30) begin
            @(negedge clk);
            acc |= level_out[1] | rise_pulse[1] | fall_pulse[1] | press_pulse[1];
        end
        check_val("ch1_glitch", 32'(acc), 32'd0);
        check_val("ch1_others", 32'(level_out), 32'h001);
        $display("ch1 glitch: any activity = %0b", acc);

        // Channel 2 held with auto-repeat
        repeat_en[2] = 1'b1;
        raw_in[2]    = 1'b1;
        wait_lvl(2, 1'b1, 20, lat);
        check_val("ch2_lat_ok", 32'(lat >= 11 && lat <= 14), 32'd1);
        check_val("ch2_rise", 32'(rise_pulse), 32'h004);
        check_val("ch2_press", 32'(press_pulse), 32'h004);
        np = 0;
        for (int k = 0; k < 4; k++) pt[k] = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (press_pulse[2]) begin
                if (np < 4) pt[np] = k;
                np++;
            end
        end
        check_val("ch2_rep_count", 32'(np), 32'd3);
        check_val("ch2_rep0", 32'(pt[0]), 32'd20);
        check_val("ch2_rep1", 32'(pt[1]), 32'd28);
        check_val("ch2_rep2", 32'(pt[2]), 32'd36);
        $display("ch2 repeat: %0d pulses at +%0d +%0d +%0d", np, pt[0], pt[1], pt[2]);

        raw_in[2] = 1'b0;
        wait_lvl(2, 1'b0, 20, lat);
        check_val("ch2_rel_lat_ok", 32'(lat >= 11 && lat <= 14), 32'd1);
        check_val("ch2_fall", 32'(fall_pulse), 32'h004);
        check_val("ch2_fall_nopress", 32'(press_pulse), 32'd0);
        acc = 1'b0;
        repeat (30) begin
            @(negedge clk);
            acc |= press_pulse[2];
        end
        check_val("ch2_rel_quiet", 32'(acc), 32'd0);
        $display("ch2 release: latency %0d, later presses = %0b", lat, acc);

        // Channel 2 held without auto-repeat
        repeat_en[2] = 1'b0;
        raw_in[2]    = 1'b1;
        wait_lvl(2, 1'b1, 20, lat);
        check_val("ch2n_press", 32'(press_pulse), 32'h004);
        acc = 1'b0;
        repeat (40) begin
            @(negedge clk);
            acc |= press_pulse[2];
        end
        check_val("ch2n_no_repeat", 32'(acc), 32'd0);
        raw_in[2] = 1'b0;
        wait_lvl(2, 1'b0, 20, lat);
        check_val("ch2n_rel_lat_ok", 32'(lat >= 11 && lat <= 14), 32'd1);
        $display("ch2 no-repeat: extra presses = %0b, release latency %0d", acc, lat);

        // Channels 0 and 3 toggled together
        raw_in[0] = 1'b0;
        raw_in[3] = 1'b1;
        wait_lvl(3, 1'b1, 20, lat);
        check_val("sim_level", 32'(level_out), 32'h008);
        check_val("sim_rise", 32'(rise_pulse), 32'h008);
        check_val("sim_fall", 32'(fall_pulse), 32'h001);
        $display("ch0/ch3 simultaneous: level=%03h rise=%03h fall=%03h", level_out, rise_pulse, fall_pulse);

        // Reset in the middle of a repeat hold
        repeat_en[2] = 1'b1;
        raw_in[2]    = 1'b1;
        wait_lvl(2, 1'b1, 20, lat);
        np = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (press_pulse[2]) begin
                np = k;
                break;
            end
        end
        check_val("rst_mid_rep", 32'(np), 32'd20);
        repeat (3) @(negedge clk);
        #1 btn_reset = 1'b1;
        #1;
        check_val("rst_mid_level", 32'(level_out), 32'd0);
        check_val("rst_mid_press", 32'(press_pulse), 32'd0);
        check_val("rst_mid_rise", 32'(rise_pulse), 32'd0);
        check_val("rst_mid_tick", 32'(tick), 32'd0);
        repeat (3) @(negedge clk);
        btn_reset = 1'b0;
        wait_lvl(2, 1'b1, 20, lat);
        check_val("rst_rel_lat_ok", 32'(lat >= 11 && lat <= 14), 32'd1);
        check_val("rst_rel_level", 32'(level_out), 32'h00C);
        check_val("rst_rel_rise", 32'(rise_pulse), 32'h00C);
        check_val("rst_rel_press", 32'(press_pulse), 32'h00C);
        $display("reset mid-repeat: re-accept latency %0d, level=%03h", lat, level_out);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel button/switch conditioner for the clock/RTC front panel. Each of N_CH raw inputs is synchronised, sampled on a shared divided tick and accepted only after STABLE_N consecutive agreeing samples. Per channel it provides a debounced level, single-cycle rise and fall pulses, and an optional auto-repeat "press" pulse stream for held increment/decrement/cursor buttons. It sits between the board pins and the configuration/write FSMs, replacing the fixed two-counter front end.

## Interface
- N_CH, 9: number of channels.
- TICK_DIV, 3000000: clk cycles per sample tick (≥2).
- STABLE_N, 4: consecutive disagreeing ticks required to flip a level (≥1).
- REPEAT_DELAY, 15: ticks of continuous hold before the first repeat pulse (≥1).
- REPEAT_RATE, 5: ticks between subsequent repeat pulses (1..REPEAT_DELAY).

- clk  in  1  system clock.
- btn_reset  in  1  asynchronous, active-high reset.
- raw_in  in  N_CH  unsynchronised pin levels.
- repeat_en  in  N_CH  per-channel auto-repeat enable; clk-domain signal.
- level_out  out  N_CH  debounced level.
- rise_pulse  out  N_CH  1-cycle pulse when level_out goes 0→1.
- fall_pulse  out  N_CH  1-cycle pulse when level_out goes 1→0.
- press_pulse  out  N_CH  1-cycle pulse: rise_pulse OR repeat event.
- tick  out  1  1-cycle sample strobe (debug/shared use).

## Operation
- Reset: all flops cleared; level_out, rise/fall/press_pulse, tick = 0; tick counter, stability counters and repeat counters = 0.
- Synchroniser: two flops per channel, raw_in → sync; no other logic reads raw_in.
- Tick generator: counter 0..TICK_DIV-1, width $clog2(TICK_DIV); tick = 1 in the cycle the counter equals TICK_DIV-1; counter then wraps to 0.
- Stability filter (per channel, acts only when tick = 1):
  - sync == level: stab_cnt ← 0.
  - sync != level and stab_cnt < STABLE_N-1: stab_cnt ← stab_cnt+1.
  - sync != level and stab_cnt == STABLE_N-1: level ← sync, stab_cnt ← 0.
  - One agreeing tick restarts the count; glitches shorter than STABLE_N ticks never propagate.
- Edge pulses: registered; rise/fall_pulse asserted in the first cycle level_out shows its new value, for exactly one cycle.
- Auto-repeat (per channel):
  - rep_cnt cleared on the tick the level flips high, whenever level = 0, and whenever repeat_en = 0.
  - Each tick with level = 1 and repeat_en = 1: rep_cnt+1; on reaching REPEAT_DELAY, issue repeat event, rep_cnt ← REPEAT_DELAY-REPEAT_RATE.
  - Width $clog2(REPEAT_DELAY+1); never overflows.
- press_pulse = rise_pulse | repeat event, in the same cycle as level/counter updates; never two pulses in one cycle.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.

## Timing
- Latency raw edge → level_out: 2 sync cycles + STABLE_N ticks; min (STABLE_N-1)·TICK_DIV+3, max STABLE_N·TICK_DIV+2 clk cycles.
- Repeat events: first at REPEAT_DELAY ticks after the rise tick, then every REPEAT_RATE ticks while held.
- All outputs are registered; no combinational path from raw_in or repeat_en to outputs.
- Reset mid-operation: immediate clear of all state; an input held high through reset is re-accepted after release with normal latency and generates rise_pulse/press_pulse.
- Release during repeat: fall_pulse on level flip, no further press_pulse; rep_cnt cleared.
- repeat_en dropped mid-hold: repeat events stop immediately; re-enabling restarts the REPEAT_DELAY wait.

## Test plan
- Params TICK_DIV=4, STABLE_N=3, REPEAT_DELAY=5, REPEAT_RATE=2. Reset held 5 cycles, raw_in=0 → all outputs 0; tick pulses every 4 cycles after release.
- raw_in[0] 0→1, held → level_out[0]=1 within 11..14 cycles; rise_pulse[0] and press_pulse[0] high exactly 1 cycle; other channels unaffected.
- raw_in[1] high for 8 cycles, then low (2 ticks) → level_out[1] stays 0, no pulses.
- raw_in[2] held with repeat_en[2]=1 → press_pulse at rise, then 20, 28, 36 cycles after it; release → fall_pulse[2], pulses stop; with repeat_en[2]=0 → only the rise press.
- raw_in[0] and raw_in[3] toggled the same cycle → both level_out bits and rise_pulse bits update in the same cycle.
- btn_reset asserted mid-repeat with raw_in[2]=1 → outputs 0 same cycle; after release, level_out[2]=1 and rise_pulse[2] within 11..14 cycles.
